// File: rtl/sdm_interp.sv
// Linear-interpolating upsampler for the SDM DAC path: one buffered PCM input per segment,
// 2**OSR_LOG2 interpolated outputs per segment, one output strobe every CLK_DIV clocks.
module sdm_interp #(
    parameter int unsigned OSR_LOG2 = 6,
    parameter int unsigned CLK_DIV  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [15:0] din,
    output logic        valid_out,
    output logic [15:0] dout,
    output logic        underrun
);

    localparam int unsigned AccW = 17 + OSR_LOG2;
    localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] TickMax = CntW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e                 state_q;
    logic [CntW-1:0]        tick_cnt_q;
    logic                   buf_valid_q;
    logic [15:0]            buf_data_q;
    logic [15:0]            c_q;
    logic signed [16:0]     diff_q;
    logic signed [AccW-1:0] acc_q;
    logic [OSR_LOG2-1:0]    k_q;

    logic                   tick;
    logic                   last_step;
    logic                   do_load;
    logic signed [16:0]     load_diff;
    logic signed [AccW-1:0] c_scaled;
    logic signed [AccW-1:0] acc_step;

    assign tick      = (tick_cnt_q == TickMax);
    assign last_step = (k_q == {OSR_LOG2{1'b1}});
    assign ready_in  = !buf_valid_q;

    // 17-bit difference cannot overflow even for a full-scale swing.
    assign load_diff = {buf_data_q[15], buf_data_q} - {c_q[15], c_q};
    assign c_scaled  = {c_q[15], c_q, {OSR_LOG2{1'b0}}};
    assign acc_step  = acc_q + {{OSR_LOG2{diff_q[16]}}, diff_q};

    // A new segment starts whenever a sample is waiting at a segment boundary.
    always_comb begin
        do_load = 1'b0;
        if (tick && buf_valid_q) begin
            unique case (state_q)
                StIdle:  do_load = 1'b1;
                StRun:   do_load = last_step;
                StHold:  do_load = 1'b1;
                default: do_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            c_q         <= '0;
            diff_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            valid_out   <= 1'b0;
            dout        <= '0;
            underrun    <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CntW'(1);
            valid_out  <= 1'b0;
            underrun   <= 1'b0;

            if (valid_in && !buf_valid_q) begin
                buf_valid_q <= 1'b1;
                buf_data_q  <= din;
            end

            if (tick) begin
                unique case (state_q)
                    StIdle: ;
                    StRun: begin
                        valid_out <= 1'b1;
                        dout      <= 16'(acc_q >>> OSR_LOG2);
                        acc_q     <= acc_step;
                        k_q       <= k_q + OSR_LOG2'(1);
                        if (last_step && !buf_valid_q) begin
                            // Park exactly on C so the hold value matches the segment end.
                            acc_q    <= c_scaled;
                            diff_q   <= '0;
                            underrun <= 1'b1;
                            state_q  <= StHold;
                        end
                    end
                    StHold: begin
                        valid_out <= 1'b1;
                        dout      <= c_q;
                    end
                    default: state_q <= StIdle;
                endcase
            end

            // Load overrides the per-step updates above; the buffer cannot be
            // accepting in the same cycle because it is full.
            if (do_load) begin
                c_q         <= buf_data_q;
                diff_q      <= load_diff;
                acc_q       <= c_scaled;
                k_q         <= '0;
                buf_valid_q <= 1'b0;
                state_q     <= StRun;
            end
        end
    end

endmodule

// File: tb/tb_sdm_interp.sv
// Randomised bench for sdm_interp: expected output streams come from a segment-by-segment
// interpolation model written directly from the output formula P + floor(k*(C-P)/2**L).
`timescale 1ns/1ps
module tb_sdm_interp;

    localparam int unsigned OSR_LOG2 = 2;
    localparam int unsigned CLK_DIV  = 4;
    localparam int SEG = 1 << OSR_LOG2;
    localparam int CLK_NS = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] din = '0;
    logic        ready_in;
    logic        valid_out;
    logic [15:0] dout;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    int          obs[$];
    time         obs_t[$];
    int          acc_seen[$];
    int          n_underrun;
    int          hold_viol;
    logic [15:0] last_dout;
    int          exp_q[$];

    sdm_interp #(
        .OSR_LOG2(OSR_LOG2),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .din      (din),
        .valid_out(valid_out),
        .dout     (dout),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Observation on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            obs.delete();
            obs_t.delete();
            acc_seen.delete();
            n_underrun = 0;
            hold_viol  = 0;
        end else begin
            if (valid_out) begin
                obs.push_back(int'($signed(dout)));
                obs_t.push_back($time - 5);
            end else if (dout !== last_dout) begin
                hold_viol++;
            end
            if (underrun) n_underrun++;
            if (valid_in && ready_in) acc_seen.push_back(int'($signed(din)));
        end
        last_dout = dout;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Ideal output stream for samples fed without gaps, followed by held samples.
    task automatic build_model(input int s[$], input int n_hold);
        int p;
        exp_q.delete();
        p = 0;
        foreach (s[j]) begin
            for (int k = 0; k < SEG; k++) exp_q.push_back(p + floor_div(k * (s[j] - p), SEG));
            p = s[j];
        end
        for (int h = 0; h < n_hold; h++) exp_q.push_back(p);
    endtask

    task automatic apply_reset();
        valid_in = 1'b0;
        din      = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input int x);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        din      = 16'(x);
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (ready_in) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept sample %0d not accepted within 200 cycles", x);
        end
    endtask

    task automatic wait_strobes(input int n);
        for (int c = 0; c < 400 && obs.size() < n; c++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (obs.size() < n) begin
            errors++;
            $display("FAIL strobe_count got %0d strobes, required %0d", obs.size(), n);
        end
    endtask

    task automatic test_reset();
        int s[$];
        bit seen;
        apply_reset();
        send(100);
        send(200);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = valid_out;
        end
        checks++;
        if (valid_out !== 1'b1 || ready_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_precond valid_out=%b ready_in=%b, required 1 0", valid_out,
                     ready_in);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || dout !== 16'd0 || ready_in !== 1'b1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_async valid_out=%b dout=%0d ready_in=%b underrun=%b, required 0 0 1 0",
                     valid_out, dout, ready_in, underrun);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(40);
        wait_strobes(SEG + 2);
        s = '{40};
        build_model(s, 2);
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_resume[%0d] got %0d required %0d", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ramp();
        int s[$];
        time t_acc;
        apply_reset();
        send(100);
        t_acc = $time - 1;
        send(200);
        wait_strobes(2 * SEG + 3);
        s = '{100, 200};
        build_model(s, 3);
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ramp_dout[%0d] got %0d required %0d", i, obs[i], exp_q[i]);
            end
        end
        for (int i = 1; i < obs_t.size(); i++) begin
            checks++;
            if (obs_t[i] - obs_t[i-1] !== time'(CLK_DIV * CLK_NS)) begin
                errors++;
                $display("FAIL ramp_period[%0d] got %0t required %0d", i, obs_t[i] - obs_t[i-1],
                         CLK_DIV * CLK_NS);
            end
        end
        if (obs_t.size() > 0) begin
            checks++;
            if (obs_t[0] <= t_acc || obs_t[0] - t_acc > time'(2 * CLK_DIV * CLK_NS)) begin
                errors++;
                $display("FAIL ramp_latency got %0t required 1..%0d", obs_t[0] - t_acc,
                         2 * CLK_DIV * CLK_NS);
            end
        end
        checks++;
        if (n_underrun !== 1 || hold_viol !== 0) begin
            errors++;
            $display("FAIL ramp_underrun got %0d pulses %0d stray dout changes, required 1 0",
                     n_underrun, hold_viol);
        end
    endtask

    task automatic test_negative_floor();
        int s[$];
        apply_reset();
        send(-3);
        wait_strobes(SEG + 3);
        s = '{-3};
        build_model(s, 3);
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL neg_floor[%0d] got %0d required %0d", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_full_scale();
        int s[$];
        apply_reset();
        send(32767);
        send(-32768);
        wait_strobes(2 * SEG + 3);
        s = '{32767, -32768};
        build_model(s, 3);
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_scale[%0d] got %0d required %0d", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (n_underrun !== 1) begin
            errors++;
            $display("FAIL full_scale_underrun got %0d required 1", n_underrun);
        end
    endtask

    task automatic test_underrun_resume();
        int c;
        int s[$];
        c = int'($urandom_range(60000)) - 30000;
        apply_reset();
        send(c);
        wait_strobes(SEG + 3);
        checks++;
        if (n_underrun !== 1) begin
            errors++;
            $display("FAIL stall_underrun got %0d required 1", n_underrun);
        end
        send(c + 8);
        // Stall leaves four hold strobes of C: three observed, one on the loading tick.
        wait_strobes(SEG + 4 + SEG + 2);
        s = '{c};
        build_model(s, 4);
        begin
            int p;
            p = c;
            for (int k = 0; k < SEG; k++) exp_q.push_back(p + floor_div(k * 8, SEG));
            exp_q.push_back(c + 8);
            exp_q.push_back(c + 8);
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL resume_dout[%0d] C=%0d got %0d required %0d", i, c, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (n_underrun !== 2 || hold_viol !== 0) begin
            errors++;
            $display("FAIL resume_underrun got %0d pulses %0d stray dout changes, required 2 0",
                     n_underrun, hold_viol);
        end
    endtask

    task automatic test_backpressure();
        int s[$];
        int idx;
        apply_reset();
        for (int j = 0; j < 6; j++) s.push_back(int'($urandom_range(65535)) - 32768);
        idx = 0;
        for (int cyc = 0; cyc < 2000 && idx < s.size(); cyc++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            if (ready_in) begin
                din = 16'(s[idx]);
                idx++;
            end else begin
                din = 16'($urandom);
            end
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        wait_strobes(SEG * s.size() + 3);
        checks++;
        if (acc_seen.size() !== s.size()) begin
            errors++;
            $display("FAIL bp_accept_count got %0d required %0d", acc_seen.size(), s.size());
        end
        for (int i = 0; i < s.size() && i < acc_seen.size(); i++) begin
            checks++;
            if (acc_seen[i] !== s[i]) begin
                errors++;
                $display("FAIL bp_accept[%0d] got %0d required %0d", i, acc_seen[i], s[i]);
            end
        end
        build_model(s, 3);
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_dout[%0d] got %0d required %0d", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (n_underrun !== 1 || hold_viol !== 0) begin
            errors++;
            $display("FAIL bp_underrun got %0d pulses %0d stray dout changes, required 1 0",
                     n_underrun, hold_viol);
        end
    endtask

    initial begin
        apply_reset();
        checks++;
        if (valid_out !== 1'b0 || dout !== 16'd0 || underrun !== 1'b0 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_state valid_out=%b dout=%0d underrun=%b ready_in=%b", valid_out,
                     dout, underrun, ready_in);
        end
        test_reset();
        test_ramp();
        test_negative_floor();
        test_full_scale();
        test_underrun_resume();
        test_backpressure();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
